// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch state encoding, PC source codes and width defaults
package fetch_unit_pkg;

    localparam int FETCH_DATA_W = 16;
    localparam int FETCH_ADDR_W = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic PC_SRC_INC = 1'b0;
    localparam logic PC_SRC_BUS = 1'b1;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer driving memory reads, IR handshake and PC controls
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_enable,
    output logic              pc_select,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              mem_req_q, ir_valid_q;

    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign ir_out    = ir_q;
    assign ir_valid  = ir_valid_q;
    assign pc_enable = flush | ((state_q == FETCH_REQ) & mem_ack);
    assign pc_select = flush ? PC_SRC_BUS : PC_SRC_INC;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (!flush) begin
                    state_d = FETCH_REQ;
                    addr_d  = pc_in;
                end
            end
            FETCH_REQ: begin
                if (flush) begin
                    // An in-flight read cannot be cancelled; let it finish and drop the data.
                    state_d = mem_ack ? FETCH_IDLE : FETCH_DRAIN;
                end else if (mem_ack) begin
                    state_d = FETCH_HOLD;
                    ir_d    = mem_rdata;
                end
            end
            FETCH_HOLD: begin
                if (flush) begin
                    state_d = FETCH_IDLE;
                end else if (ir_ready) begin
                    state_d = FETCH_REQ;
                    addr_d  = pc_in;
                end
            end
            FETCH_DRAIN: begin
                if (mem_ack) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH_IDLE;
            addr_q     <= '0;
            ir_q       <= '0;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            mem_req_q  <= (state_d == FETCH_REQ) || (state_d == FETCH_DRAIN);
            ir_valid_q <= (state_d == FETCH_HOLD);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in;
    logic        pc_enable, pc_select;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // environment program counter and transaction-level expectation
    logic [15:0] pc;
    logic        m_known = 1'b0;
    logic        m_req, m_disc, m_have;
    logic [15:0] m_addr, m_data;
    logic        d_rst, d_flush, d_ack, d_ready;
    logic [15:0] d_rdata, d_bus;
    logic        exp_en;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .pc_enable (pc_enable),
        .pc_select (pc_select),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        exp_en = d_flush | (m_req & !m_disc & d_ack);
        if (m_known) begin
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
            if (m_req) chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
            chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_have});
            chk("ir_out", {16'd0, ir_out}, {16'd0, m_data});
            chk("pc_enable", {31'd0, pc_enable}, {31'd0, exp_en});
            if (exp_en) chk("pc_select", {31'd0, pc_select}, {31'd0, d_flush});
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic a, input logic [15:0] rd,
                         input logic rdy, input logic [15:0] bus);
        @(negedge clk);
        d_rst = r; d_flush = f; d_ack = a; d_rdata = rd; d_ready = rdy; d_bus = bus;
        rst = r; flush = f; mem_ack = a; mem_rdata = rd; ir_ready = rdy; pc_in = pc;
        #2;
        compare();
    endtask

    task automatic commit();
        if (m_known && exp_en) pc = d_flush ? d_bus : pc + 16'd1;
        if (!d_rst) begin
            m_known = 1'b1;
            m_req = 1'b0; m_disc = 1'b0; m_have = 1'b0; m_addr = '0; m_data = '0;
        end else if (d_flush) begin
            if (m_req && d_ack) begin
                m_req = 1'b0; m_disc = 1'b0;
            end else if (m_req) begin
                m_disc = 1'b1;
            end
            m_have = 1'b0;
        end else if (m_req) begin
            if (d_ack) begin
                if (!m_disc) begin
                    m_have = 1'b1; m_data = d_rdata;
                end
                m_req = 1'b0; m_disc = 1'b0;
            end
        end else if (m_have) begin
            if (d_ready) begin
                m_have = 1'b0; m_req = 1'b1; m_addr = pc_in;
            end
        end else begin
            m_req = 1'b1; m_disc = 1'b0; m_addr = pc_in;
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic a, input logic [15:0] rd,
                       input logic rdy, input logic [15:0] bus);
        drive(r, f, a, rd, rdy, bus);
        commit();
    endtask

    initial begin
        int pulses;
        pc = 16'h0000;
        rst = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0; pc_in = '0;

        cyc(0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir_out", {16'd0, ir_out}, 32'd0);
        commit();

        // reset release with zero-wait memory
        cyc(1, 0, 1, 16'h1234, 1, 16'h0);
        drive(1, 0, 1, 16'h1234, 1, 16'h0);
        chk("c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c1_mem_addr", {16'd0, mem_addr}, 32'h0000);
        chk("c1_pc_enable", {31'd0, pc_enable}, 32'd1);
        chk("c1_pc_select", {31'd0, pc_select}, 32'd0);
        commit();
        pc = 16'h0010;
        drive(1, 0, 0, 16'h0, 1, 16'h0);
        chk("c2_ir_out", {16'd0, ir_out}, 32'h1234);
        chk("c2_ir_valid", {31'd0, ir_valid}, 32'd1);
        commit();

        // three wait states at 0x0010
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, (i == 3), 16'hBEEF, 0, 16'h0);
            chk("stall_addr", {16'd0, mem_addr}, 32'h0010);
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            pulses += int'(pc_enable);
            commit();
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL stall_pulses: got %0d expected 1", pulses);
        end

        // decoder back-pressure
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 16'h5555, 0, 16'h0);
            chk("bp_ir_out", {16'd0, ir_out}, 32'hBEEF);
            chk("bp_pc_enable", {31'd0, pc_enable}, 32'd0);
            commit();
        end
        cyc(1, 0, 0, 16'h0, 1, 16'h0);

        // flush in REQ without ack, target 0x0200
        drive(1, 1, 0, 16'h0, 0, 16'h0200);
        chk("fl_addr_inc", {16'd0, mem_addr}, 32'h0011);
        chk("fl_pc_enable", {31'd0, pc_enable}, 32'd1);
        chk("fl_pc_select", {31'd0, pc_select}, 32'd1);
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, (i == 2), 16'hAAAA, 1, 16'h0);
            chk("drain_addr", {16'd0, mem_addr}, 32'h0011);
            chk("drain_ir_valid", {31'd0, ir_valid}, 32'd0);
            commit();
        end
        cyc(1, 0, 0, 16'h0, 1, 16'h0);

        // flush coincident with ack
        drive(1, 1, 1, 16'hDEAD, 1, 16'h0300);
        chk("fa_addr", {16'd0, mem_addr}, 32'h0200);
        chk("fa_pc_select", {31'd0, pc_select}, 32'd1);
        commit();
        drive(1, 0, 0, 16'h0, 1, 16'h0);
        chk("fa_ir_out", {16'd0, ir_out}, 32'hBEEF);
        chk("fa_ir_valid", {31'd0, ir_valid}, 32'd0);
        commit();
        drive(1, 1, 0, 16'h0, 1, 16'h0400);
        chk("fa_next_addr", {16'd0, mem_addr}, 32'h0300);
        commit();

        // reset while draining
        drive(0, 0, 0, 16'h0, 1, 16'h0);
        chk("pre_rst_drain", {31'd0, mem_req}, 32'd1);
        commit();
        drive(1, 0, 0, 16'h0, 1, 16'h0);
        chk("rd_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rd_ir_out", {16'd0, ir_out}, 32'd0);
        chk("rd_ir_valid", {31'd0, ir_valid}, 32'd0);
        commit();

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(63) != 0), ($urandom_range(9) == 0), $urandom_range(1) == 1,
                16'($urandom), $urandom_range(1) == 1, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
